mp_mul_iter: RTL and testbench

- Iterative, handshaked, multi-precision unsigned multiplier.
- It is the parametrised successor to the flat combinational multiplier wrapper. It computes A*B, or A*A in square mode, over NUM_ELEMENTS-word operands by accumulating ROWS_PER_CYCLE partial-product rows per clock.
- It trades latency for area.
- It sits between operand-staging logic and the modular-reduction stage, with valid/ready on both sides.

---
 rtl/mp_mul_iter.sv | 123 ++++++++++++
 tb/tb_mp_mul_iter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_mul_iter.sv
// Iterative multi-precision unsigned multiplier (A*B or A*A).
// Accumulates ROWS_PER_CYCLE partial-product rows per clock.
module mp_mul_iter #(
    parameter int NUM_ELEMENTS   = 17,
    parameter int WORD_LEN       = 16,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               sq,
    input  logic [NUM_ELEMENTS*WORD_LEN-1:0]   a,
    input  logic [NUM_ELEMENTS*WORD_LEN-1:0]   b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [2*NUM_ELEMENTS*WORD_LEN-1:0] m,
    output logic                               busy
);

    localparam int W  = NUM_ELEMENTS * WORD_LEN;
    localparam int MW = 2 * W;
    localparam int PW = W + WORD_LEN;
    // B is padded so that row indices past the last word read as zero
    localparam int BW = (NUM_ELEMENTS + ROWS_PER_CYCLE) * WORD_LEN;
    localparam int RW = $clog2(NUM_ELEMENTS + ROWS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            last;
    logic [RW-1:0]   r_q;
    logic [W-1:0]    a_q;
    logic [BW-1:0]   b_q;
    logic [MW-1:0]   acc_q;
    logic [MW-1:0]   acc_sum;
    logic [WORD_LEN-1:0] bw;
    logic [PW-1:0]   pp;
    int              idx;

    assign last = (int'(r_q) + ROWS_PER_CYCLE >= NUM_ELEMENTS);
    assign m    = acc_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sum of this cycle's partial-product rows into the accumulator
    always_comb begin
        acc_sum = acc_q;
        idx     = 0;
        bw      = '0;
        pp      = '0;
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            idx     = int'(r_q) + j;
            bw      = b_q[idx*WORD_LEN +: WORD_LEN];
            pp      = {{WORD_LEN{1'b0}}, a_q} * {{W{1'b0}}, bw};
            acc_sum = acc_sum + (MW'(pp) << (idx * WORD_LEN));
        end
    end

    // Operand capture, row counter and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            r_q   <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= BW'(sq ? a : b);
            acc_q <= '0;
            r_q   <= '0;
        end else if (state_q == MUL) begin
            acc_q <= acc_sum;
            r_q   <= r_q + RW'(ROWS_PER_CYCLE);
        end
    end

endmodule

// File: tb/tb_mp_mul_iter.sv
// Self-checking bench for mp_mul_iter: three parameter sets,
// directed table vectors, stall/reset sequences, random stream.
`timescale 1ns/1ps
module tb_mp_mul_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [271:0] a_d;
    logic [271:0] b_d;
    logic         sq_d;
    logic         iv   [3];
    logic         ordy [3];
    logic         inr  [3];
    logic         outv [3];
    logic         bsy  [3];
    logic [63:0]  m0;
    logic [63:0]  m1;
    logic [543:0] m2;

    logic [543:0] expq [3][$];
    int n_tests = 0;
    int n_fail  = 0;
    logic prod_done;

    typedef struct {
        int          sel;
        logic        sq;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] m;
        int          lat;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    mp_mul_iter #(.NUM_ELEMENTS(4), .WORD_LEN(8), .ROWS_PER_CYCLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(inr[0]),
        .sq(sq_d), .a(a_d[31:0]), .b(b_d[31:0]), .out_valid(outv[0]),
        .out_ready(ordy[0]), .m(m0), .busy(bsy[0])
    );

    mp_mul_iter #(.NUM_ELEMENTS(4), .WORD_LEN(8), .ROWS_PER_CYCLE(3)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(inr[1]),
        .sq(sq_d), .a(a_d[31:0]), .b(b_d[31:0]), .out_valid(outv[1]),
        .out_ready(ordy[1]), .m(m1), .busy(bsy[1])
    );

    mp_mul_iter u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(inr[2]),
        .sq(sq_d), .a(a_d), .b(b_d), .out_valid(outv[2]),
        .out_ready(ordy[2]), .m(m2), .busy(bsy[2])
    );

    function automatic logic [543:0] get_m(int k);
        if (k == 0) return 544'(m0);
        if (k == 1) return 544'(m1);
        return m2;
    endfunction

    task automatic check(string nm, logic [543:0] act, logic [543:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop and compare on every output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (inr[k] && bsy[k]) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ready_while_busy dut%0d: in_ready=1 busy=1 required not both", k);
                end
                if (outv[k] && ordy[k]) begin
                    if (expq[k].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out dut%0d: got %0h expected none", k, get_m(k));
                    end else begin
                        check($sformatf("sb_m dut%0d", k), get_m(k), expq[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic send(int k, logic s, logic [271:0] aa, logic [271:0] bb);
        logic [271:0] mask;
        logic [271:0] ea;
        logic [271:0] eb;
        bit ok;
        mask = (k == 2) ? '1 : 272'(32'hFFFF_FFFF);
        ea   = aa & mask;
        eb   = s ? ea : (bb & mask);
        a_d  = aa;
        b_d  = bb;
        sq_d = s;
        iv[k] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (inr[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready=0 required 1", k);
        end else begin
            expq[k].push_back(544'(ea) * 544'(eb));
        end
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        int   lat;
        logic inr_bad;
        send(v.sel, v.sq, 272'(v.a), 272'(v.b));
        lat = 0;
        inr_bad = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (inr[v.sel]) inr_bad = 1'b1;
            if (outv[v.sel]) break;
        end
        check("latency", 544'(lat), 544'(v.lat));
        check("in_ready_low", 544'(inr_bad), 544'(0));
        check("m_table", get_m(v.sel), 544'(v.m));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [271:0] ra;
        logic [271:0] rb;
        vec_t rv;
        int guard;

        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
        end
        a_d = '0;
        b_d = '0;
        sq_d = 1'b0;
        prod_done = 1'b0;

        tbl[0] = '{0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4};
        tbl[1] = '{0, 1'b1, 32'h0001_0203, 32'hDEAD_BEEF, 64'h0000_0001_040A_0C09, 4};
        tbl[2] = '{1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 2};
        tbl[3] = '{0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0, 4};
        tbl[4] = '{1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 64'hFFFF_FFFE_0000_0001, 2};

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_in_ready%0d", k), 544'(inr[k]), 544'(1));
            check($sformatf("rst_out_valid%0d", k), 544'(outv[k]), 544'(0));
            check($sformatf("rst_busy%0d", k), 544'(bsy[k]), 544'(0));
            check($sformatf("rst_m%0d", k), get_m(k), 544'(0));
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Output stall: m held, inputs ignored, ready returns after handshake
        ordy[0] = 1'b0;
        send(0, 1'b0, 272'(32'h0000_FFFF), 272'(32'h0001_0001));
        guard = 0;
        while (!outv[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("stall_reach_done", 544'(outv[0]), 544'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a_d = 272'($urandom);
            b_d = 272'($urandom);
            iv[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall_m_stable", 544'(m0), 544'(64'hFFFF_FFFF));
            check("stall_out_valid", 544'(outv[0]), 544'(1));
            check("stall_in_ready", 544'(inr[0]), 544'(0));
        end
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_in_ready", 544'(inr[0]), 544'(1));
        check("post_hs_out_valid", 544'(outv[0]), 544'(0));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of MUL
        send(0, 1'b0, 272'(32'hFFFF_FFFF), 272'(32'hFFFF_FFFF));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 544'(outv[0]), 544'(0));
        check("midrst_m", 544'(m0), 544'(0));
        check("midrst_in_ready", 544'(inr[0]), 544'(1));
        check("midrst_busy", 544'(bsy[0]), 544'(0));
        expq[0].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rv = '{0, 1'b0, 32'd3, 32'd5, 64'd15, 4};
        run_vec(rv);

        // Random stream on the default configuration
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    for (int w = 0; w < 9; w++) begin
                        ra[w*32 +: 16] = 16'($urandom);
                        rb[w*32 +: 16] = 16'($urandom);
                        if (w < 8) begin
                            ra[w*32+16 +: 16] = 16'($urandom);
                            rb[w*32+16 +: 16] = 16'($urandom);
                        end
                    end
                    if ($urandom_range(0, 7) == 0) ra = '1;
                    if ($urandom_range(0, 7) == 0) rb = '1;
                    if ($urandom_range(0, 15) == 0) rb = '0;
                    send(2, 1'($urandom_range(0, 1)), ra, rb);
                end
                prod_done = 1'b1;
            end
            begin
                guard = 0;
                while ((!prod_done || expq[2].size() != 0) && guard < 60000) begin
                    @(posedge clk);
                    #1;
                    ordy[2] = ($urandom_range(0, 3) != 0);
                    guard++;
                end
                ordy[2] = 1'b1;
                if (guard >= 60000) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL random_drain: pending=%0d required 0", expq[2].size());
                end
            end
        join

        repeat (3) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("queue_empty%0d", k), 544'(expq[k].size()), 544'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
